// File: rtl/riscv_pkg.sv
// Shared RISC-V decode types: register index width, register count and the
// decoded-instruction payload carried from decode to execute.
package riscv_pkg;

   localparam int REG_IDX_W = 5;
   localparam int NREGS     = 32;

   typedef logic [REG_IDX_W-1:0] reg_idx_t;

   localparam reg_idx_t X0 = '0;

   typedef struct packed {
      logic [6:0]  opcode;
      logic [2:0]  funct3;
      logic [6:0]  funct7;
      logic [31:0] imm;
   } inst_decoded_t;

endpackage

// File: rtl/decode_issue_ctrl_if.sv
// Decode-to-issue and issue-to-EX handshake bundle. The slave side is the
// issue controller; the master side drives decode and EX.
interface decode_issue_ctrl_if;
   import riscv_pkg::*;

   logic          dec_valid;
   logic          dec_ready;
   inst_decoded_t dec_inst;
   reg_idx_t      dec_rs1;
   reg_idx_t      dec_rs2;
   reg_idx_t      dec_rd;
   logic          dec_use_rs1;
   logic          dec_use_rs2;
   logic          dec_rd_we;
   logic          iss_valid;
   logic          iss_ready;
   inst_decoded_t iss_inst;

   modport master (
      output dec_valid, dec_inst, dec_rs1, dec_rs2, dec_rd,
             dec_use_rs1, dec_use_rs2, dec_rd_we, iss_ready,
      input  dec_ready, iss_valid, iss_inst
   );

   modport slave (
      input  dec_valid, dec_inst, dec_rs1, dec_rs2, dec_rd,
             dec_use_rs1, dec_use_rs2, dec_rd_we, iss_ready,
      output dec_ready, iss_valid, iss_inst
   );

endinterface

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one busy bit per register plus a count of
// issued-but-not-written-back writes. A set beats a clear on the same register.
module reg_scoreboard
   import riscv_pkg::*;
#(
   parameter int NREGS        = riscv_pkg::NREGS,
   parameter int MAX_INFLIGHT = 4,
   parameter int IF_W         = $clog2(MAX_INFLIGHT + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             set_en,
   input  reg_idx_t         set_idx,
   input  logic             clr_en,
   input  reg_idx_t         clr_idx,
   output logic [NREGS-1:0] busy_vec,
   output logic [IF_W-1:0]  inflight
);

   logic [NREGS-1:0] busy_q, busy_d;
   logic [NREGS-1:0] set_mask, clr_mask;
   logic [IF_W-1:0]  inflight_q, inflight_d;

   for (genvar gi = 0; gi < NREGS; gi++) begin : g_mask
      if (gi == 0) begin : g_x0
         assign set_mask[gi] = 1'b0;
         assign clr_mask[gi] = 1'b0;
      end else begin : g_reg
         assign set_mask[gi] = set_en && (set_idx == reg_idx_t'(gi));
         assign clr_mask[gi] = clr_en && (clr_idx == reg_idx_t'(gi));
      end
   end

   always_comb begin
      busy_d     = (busy_q & ~clr_mask) | set_mask;
      inflight_d = inflight_q;
      // Simultaneous issue and writeback cancel out on the counter.
      if (set_en && !clr_en) begin
         inflight_d = inflight_q + 1'b1;
      end else if (clr_en && !set_en && inflight_q != '0) begin
         inflight_d = inflight_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         busy_q     <= '0;
         inflight_q <= '0;
      end else begin
         busy_q     <= busy_d;
         inflight_q <= inflight_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst && clr_en) begin
         assert (inflight_q != '0);
      end
   end

   assign busy_vec = busy_q;
   assign inflight = inflight_q;

endmodule

// File: rtl/decode_issue_ctrl.sv
// Issue controller: single-entry issue register between decode and EX with
// RAW/WAW hazard stalls, an in-flight write cap, flush and a stall counter.
module decode_issue_ctrl
   import riscv_pkg::*;
#(
   parameter int NREGS        = riscv_pkg::NREGS,
   parameter int MAX_INFLIGHT = 4,
   parameter int CNT_W        = 32
) (
   input  logic                clk,
   input  logic                rst,
   decode_issue_ctrl_if.slave  bus,
   input  logic                wb_valid,
   input  reg_idx_t            wb_rd,
   input  logic                flush,
   output logic [NREGS-1:0]    busy_vec,
   output logic [CNT_W-1:0]    stall_cnt
);

   localparam int IF_W = $clog2(MAX_INFLIGHT + 1);

   logic             iss_valid_q, iss_valid_d;
   inst_decoded_t    iss_inst_q, iss_inst_d;
   reg_idx_t         iss_rd_q, iss_rd_d;
   logic             iss_rd_we_q, iss_rd_we_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   logic [IF_W-1:0]  inflight;
   logic [IF_W:0]    inflight_after_fire;
   logic [NREGS-1:0] eff_busy;
   logic             fire, accept, room, full, hazard, dec_ready;
   logic             sb_set, sb_clr;

   assign fire   = iss_valid_q & bus.iss_ready;
   assign sb_set = fire & iss_rd_we_q & (iss_rd_q != X0);
   assign sb_clr = wb_valid & (wb_rd != X0);

   // Writeback bypasses the RF, so its register is free now; the held
   // producer's rd is already pending even though it has not issued.
   for (genvar gi = 0; gi < NREGS; gi++) begin : g_eff
      if (gi == 0) begin : g_x0
         assign eff_busy[gi] = 1'b0;
      end else begin : g_reg
         assign eff_busy[gi] =
            (busy_vec[gi] & ~(wb_valid && wb_rd == reg_idx_t'(gi))) |
            (iss_valid_q && iss_rd_we_q && iss_rd_q == reg_idx_t'(gi));
      end
   end

   always_comb begin
      hazard = (bus.dec_use_rs1 && eff_busy[bus.dec_rs1]) ||
               (bus.dec_use_rs2 && eff_busy[bus.dec_rs2]) ||
               (bus.dec_rd_we   && eff_busy[bus.dec_rd]);
      inflight_after_fire = {1'b0, inflight} + {{IF_W{1'b0}}, fire & iss_rd_we_q};
      full      = bus.dec_rd_we && (inflight_after_fire >= (IF_W+1)'(MAX_INFLIGHT));
      room      = !iss_valid_q || fire;
      dec_ready = rst && !flush && room && !hazard && !full;
      accept    = bus.dec_valid && dec_ready;
   end

   always_comb begin
      iss_valid_d = iss_valid_q;
      iss_inst_d  = iss_inst_q;
      iss_rd_d    = iss_rd_q;
      iss_rd_we_d = iss_rd_we_q;
      if (accept) begin
         iss_valid_d = 1'b1;
         iss_inst_d  = bus.dec_inst;
         iss_rd_d    = bus.dec_rd;
         iss_rd_we_d = bus.dec_rd_we;
      end else if (fire || flush) begin
         iss_valid_d = 1'b0;
      end

      stall_cnt_d = stall_cnt_q;
      if (bus.dec_valid && !dec_ready && rst && stall_cnt_q != '1) begin
         stall_cnt_d = stall_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         iss_valid_q <= 1'b0;
         iss_inst_q  <= '0;
         iss_rd_q    <= X0;
         iss_rd_we_q <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         iss_valid_q <= iss_valid_d;
         iss_inst_q  <= iss_inst_d;
         iss_rd_q    <= iss_rd_d;
         iss_rd_we_q <= iss_rd_we_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   reg_scoreboard #(
      .NREGS        (NREGS),
      .MAX_INFLIGHT (MAX_INFLIGHT),
      .IF_W         (IF_W)
   ) u_scoreboard (
      .clk      (clk),
      .rst      (rst),
      .set_en   (sb_set),
      .set_idx  (iss_rd_q),
      .clr_en   (sb_clr),
      .clr_idx  (wb_rd),
      .busy_vec (busy_vec),
      .inflight (inflight)
   );

   assign bus.dec_ready = dec_ready;
   assign bus.iss_valid = iss_valid_q;
   assign bus.iss_inst  = iss_inst_q;
   assign stall_cnt     = stall_cnt_q;

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Directed bench for decode_issue_ctrl: hazards, bypass, capacity, flush,
// set/clear collision, stall counter saturation and mid-run reset.
module tb_decode_issue_ctrl;
   import riscv_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        wb_valid;
   reg_idx_t    wb_rd;
   logic        flush;
   logic [31:0] busy_vec;
   logic [31:0] stall_cnt;
   logic [31:0] sat_busy;
   logic [1:0]  sat_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   decode_issue_ctrl_if bus ();
   decode_issue_ctrl_if bus_sat ();

   decode_issue_ctrl #(.NREGS(32), .MAX_INFLIGHT(4), .CNT_W(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .wb_valid  (wb_valid),
      .wb_rd     (wb_rd),
      .flush     (flush),
      .busy_vec  (busy_vec),
      .stall_cnt (stall_cnt)
   );

   // Narrow counter instance held permanently stalled by flush.
   decode_issue_ctrl #(.NREGS(32), .MAX_INFLIGHT(4), .CNT_W(2)) dut_sat (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus_sat),
      .wb_valid  (1'b0),
      .wb_rd     (X0),
      .flush     (1'b1),
      .busy_vec  (sat_busy),
      .stall_cnt (sat_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_dec(input logic v, input reg_idx_t rs1, input logic u1,
                          input reg_idx_t rs2, input logic u2,
                          input reg_idx_t rd, input logic we, input logic [31:0] imm);
      bus.dec_valid   = v;
      bus.dec_rs1     = rs1;
      bus.dec_use_rs1 = u1;
      bus.dec_rs2     = rs2;
      bus.dec_use_rs2 = u2;
      bus.dec_rd      = rd;
      bus.dec_rd_we   = we;
      bus.dec_inst    = {7'h33, 3'd0, 7'd0, imm};
   endtask

   task automatic idle();
      set_dec(1'b0, X0, 1'b0, X0, 1'b0, X0, 1'b0, 32'h0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0; flush = 1'b0; wb_valid = 1'b0; wb_rd = X0;
      bus.iss_ready         = 1'b0;
      bus_sat.dec_valid     = 1'b1;
      bus_sat.dec_inst      = '0;
      bus_sat.dec_rs1       = X0;
      bus_sat.dec_rs2       = X0;
      bus_sat.dec_rd        = X0;
      bus_sat.dec_use_rs1   = 1'b0;
      bus_sat.dec_use_rs2   = 1'b0;
      bus_sat.dec_rd_we     = 1'b0;
      bus_sat.iss_ready     = 1'b0;
      set_dec(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 32'hAA);

      // Reset held with decode valid
      repeat (3) tick();
      #1;
      chk("rst_dec_ready", bus.dec_ready, 0);
      chk("rst_iss_valid", bus.iss_valid, 0);
      chk("rst_busy",      busy_vec, 0);
      chk("rst_stall",     stall_cnt, 0);
      chk("rst_inflight",  dut.inflight, 0);
      idle();
      rst = 1'b1;
      tick();

      // RAW on a held producer, then writeback bypass
      set_dec(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 32'h100);
      #1 chk("raw_prod_ready", bus.dec_ready, 1);
      tick();
      chk("raw_prod_issued", bus.iss_valid, 1);
      chk("raw_prod_imm", bus.iss_inst.imm, 32'h100);
      set_dec(1'b1, 5'd5, 1'b1, X0, 1'b0, 5'd6, 1'b1, 32'h101);
      #1 chk("raw_cons_blocked_held", bus.dec_ready, 0);
      tick();
      chk("raw_stall_cnt1", stall_cnt, 1);
      chk("raw_payload_stable", bus.iss_inst.imm, 32'h100);
      bus.iss_ready = 1'b1;
      #1 chk("raw_cons_blocked_fire", bus.dec_ready, 0);
      tick();
      bus.iss_ready = 1'b0;
      chk("raw_busy5", busy_vec, 32'h20);
      chk("raw_prod_gone", bus.iss_valid, 0);
      chk("raw_inflight1", dut.inflight, 1);
      #1 chk("raw_cons_blocked_busy", bus.dec_ready, 0);
      wb_valid = 1'b1; wb_rd = 5'd5;
      #1 chk("raw_cons_bypass", bus.dec_ready, 1);
      tick();
      wb_valid = 1'b0;
      idle();
      chk("raw_busy_cleared", busy_vec, 0);
      chk("raw_cons_imm", bus.iss_inst.imm, 32'h101);
      chk("raw_stall_cnt2", stall_cnt, 2);
      chk("raw_inflight0", dut.inflight, 0);
      bus.iss_ready = 1'b1;
      tick();
      bus.iss_ready = 1'b0;
      chk("raw_busy6", busy_vec, 32'h40);
      wb_valid = 1'b1; wb_rd = 5'd6;
      tick();
      wb_valid = 1'b0;
      chk("raw_wb6", busy_vec, 0);

      // x0 writer never marks busy
      set_dec(1'b1, X0, 1'b0, X0, 1'b0, X0, 1'b1, 32'h200);
      #1 chk("x0_wr_ready", bus.dec_ready, 1);
      tick();
      bus.iss_ready = 1'b1;
      set_dec(1'b1, X0, 1'b1, X0, 1'b1, 5'd9, 1'b0, 32'h201);
      #1 chk("x0_dep_ready", bus.dec_ready, 1);
      tick();
      chk("x0_busy", busy_vec, 0);
      chk("x0_inflight", dut.inflight, 0);
      chk("x0_dep_imm", bus.iss_inst.imm, 32'h201);
      idle();
      tick();
      bus.iss_ready = 1'b0;
      chk("x0_drained", bus.iss_valid, 0);

      // Capacity: four writers in flight
      bus.iss_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         set_dec(1'b1, X0, 1'b0, X0, 1'b0, reg_idx_t'(i), 1'b1, 32'h300 + i);
         #1 chk("cap_wr_ready", bus.dec_ready, 1);
         tick();
      end
      idle();
      tick();
      bus.iss_ready = 1'b0;
      chk("cap_inflight4", dut.inflight, 4);
      chk("cap_busy", busy_vec, 32'h1E);
      set_dec(1'b1, X0, 1'b0, X0, 1'b0, 5'd10, 1'b1, 32'h310);
      #1 chk("cap_full_stall", bus.dec_ready, 0);
      set_dec(1'b1, 5'd11, 1'b1, 5'd12, 1'b1, X0, 1'b0, 32'h311);
      #1 chk("cap_store_ok", bus.dec_ready, 1);
      tick();
      bus.iss_ready = 1'b1;
      set_dec(1'b1, X0, 1'b0, X0, 1'b0, 5'd10, 1'b1, 32'h310);
      wb_valid = 1'b1; wb_rd = 5'd1;
      #1 chk("cap_full_wb_cycle", bus.dec_ready, 0);
      tick();
      wb_valid = 1'b0;
      bus.iss_ready = 1'b0;
      chk("cap_inflight3", dut.inflight, 3);
      chk("cap_store_fired", bus.iss_valid, 0);
      #1 chk("cap_5th_ready", bus.dec_ready, 1);
      tick();
      idle();
      chk("cap_5th_imm", bus.iss_inst.imm, 32'h310);
      bus.iss_ready = 1'b1;
      tick();
      bus.iss_ready = 1'b0;
      chk("cap_busy2", busy_vec, 32'h41C);
      chk("cap_inflight4b", dut.inflight, 4);
      for (int i = 0; i < 4; i++) begin
         wb_valid = 1'b1;
         wb_rd = (i == 3) ? 5'd10 : reg_idx_t'(i + 2);
         tick();
      end
      wb_valid = 1'b0;
      chk("cap_drained_busy", busy_vec, 0);
      chk("cap_drained_inflight", dut.inflight, 0);

      // Flush without and with a simultaneous fire
      set_dec(1'b1, X0, 1'b0, X0, 1'b0, 5'd12, 1'b1, 32'h400);
      tick();
      set_dec(1'b1, X0, 1'b0, X0, 1'b0, 5'd13, 1'b1, 32'h401);
      flush = 1'b1;
      #1 chk("flush_blocks_decode", bus.dec_ready, 0);
      tick();
      flush = 1'b0;
      idle();
      chk("flush_kill", bus.iss_valid, 0);
      chk("flush_busy", busy_vec, 0);
      chk("flush_inflight", dut.inflight, 0);
      set_dec(1'b1, X0, 1'b0, X0, 1'b0, 5'd12, 1'b1, 32'h402);
      tick();
      idle();
      flush = 1'b1;
      bus.iss_ready = 1'b1;
      tick();
      flush = 1'b0;
      bus.iss_ready = 1'b0;
      chk("flush_fire_valid", bus.iss_valid, 0);
      chk("flush_fire_busy", busy_vec, 32'h1000);
      chk("flush_fire_inflight", dut.inflight, 1);
      wb_valid = 1'b1; wb_rd = 5'd12;
      tick();
      wb_valid = 1'b0;
      chk("flush_wb12", busy_vec, 0);

      // Set/clear collision on x7
      set_dec(1'b1, X0, 1'b0, X0, 1'b0, 5'd7, 1'b1, 32'h500);
      tick();
      bus.iss_ready = 1'b1;
      set_dec(1'b1, X0, 1'b0, X0, 1'b0, 5'd8, 1'b1, 32'h501);
      #1 chk("col_x8_ready", bus.dec_ready, 1);
      tick();
      idle();
      tick();
      bus.iss_ready = 1'b0;
      chk("col_busy78", busy_vec, 32'h180);
      chk("col_inflight2", dut.inflight, 2);
      set_dec(1'b1, X0, 1'b0, X0, 1'b0, 5'd7, 1'b1, 32'h502);
      #1 chk("col_waw_blocked", bus.dec_ready, 0);
      wb_valid = 1'b1; wb_rd = 5'd7;
      #1 chk("col_waw_bypass", bus.dec_ready, 1);
      tick();
      wb_valid = 1'b0;
      idle();
      chk("col_busy8", busy_vec, 32'h100);
      chk("col_inflight1", dut.inflight, 1);
      bus.iss_ready = 1'b1;
      wb_valid = 1'b1; wb_rd = 5'd7;
      tick();
      bus.iss_ready = 1'b0;
      wb_valid = 1'b0;
      chk("col_set_wins", busy_vec, 32'h180);
      chk("col_inflight_same", dut.inflight, 1);
      wb_valid = 1'b1; wb_rd = 5'd7;
      tick();
      wb_valid = 1'b0;
      chk("col_wb7", busy_vec, 32'h100);

      // Saturating stall counter on the narrow instance
      chk("sat_cnt_a", sat_cnt, 2'd3);
      tick();
      chk("sat_cnt_b", sat_cnt, 2'd3);
      chk("sat_busy", sat_busy, 0);

      // Reset mid-operation discards the pending x8 write
      set_dec(1'b1, 5'd8, 1'b1, X0, 1'b0, 5'd14, 1'b1, 32'h600);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      #1;
      chk("mrst_busy", busy_vec, 0);
      chk("mrst_inflight", dut.inflight, 0);
      chk("mrst_stall", stall_cnt, 0);
      chk("mrst_iss_valid", bus.iss_valid, 0);
      chk("mrst_dep_ready", bus.dec_ready, 1);
      idle();
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/decode_issue_ctrl.md
Name: decode_issue_ctrl

Overview:
- Issue controller between the decode stage and execute: holds one decoded instruction in an issue register and releases it to EX with a valid/ready handshake.
- Tracks pending register writes in a 32-entry scoreboard.
- Stalls decode on RAW/WAW hazards or when too many writes are in flight.
- Drops the held instruction on a pipeline flush.

Parameters:
- NREGS, 32, architectural integer registers; x0 is never busy.
- MAX_INFLIGHT, 4, maximum issued-but-not-written-back register writes.
- CNT_W, 32, width of the stall performance counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- dec_valid  in  1  decode presents an instruction
- dec_ready  out  1  controller accepts the decode instruction this cycle
- dec_inst  in  inst_decoded_t  decoded instruction payload
- dec_rs1, dec_rs2, dec_rd  in  5 each  register indices
- dec_use_rs1, dec_use_rs2, dec_rd_we  in  1 each  operand-use and write-enable flags
- iss_valid  out  1  issue register holds a valid instruction
- iss_ready  in  1  EX accepts the instruction
- iss_inst  out  inst_decoded_t  held payload
- wb_valid  in  1  writeback completes a register write
- wb_rd  in  5  register written back
- flush  in  1  kill the held instruction; block decode this cycle
- busy_vec  out  NREGS  scoreboard, for debug
- stall_cnt  out  CNT_W  cycles with dec_valid=1 and dec_ready=0

Behaviour:
- Reset (rst=0 at posedge clk): iss_valid=0, busy_vec=0, inflight=0, stall_cnt=0, iss_inst=0.
- dec_ready is combinational: 0 whenever rst=0.
- Issue handshake: fires when iss_valid & iss_ready. On fire with rd_we=1 and rd!=0:
  - busy[rd] is set at the next edge.
  - inflight increments.
- Writeback: wb_valid with wb_rd!=0 clears busy[wb_rd] and decrements inflight.
  - wb_valid with wb_rd=0 is ignored.
  - Writeback never underflows: inflight=0 plus wb_valid is a protocol error; the counter holds and an assertion fires.
- Same-edge set and clear of one register: set wins. The older write completes and the new writer is now pending.
- Same-edge issue and writeback: inflight is unchanged.
- Effective busy for hazard checks is busy_vec with the wb_rd bit masked off when wb_valid, since the RF writes through.
  - Also counts as busy: the rd of the instruction in the issue register when iss_valid & rd_we & rd!=0. This covers the RAW case where the producer has not issued yet.
- Hazard is any of:
  - dec_use_rs1 and rs1 effective-busy;
  - dec_use_rs2 and rs2 effective-busy;
  - dec_rd_we and rd effective-busy (WAW).
  - Index 0 never hazards.
- Capacity:
  - room = !iss_valid | fire.
  - full = (inflight + (fire & rd_we)) >= MAX_INFLIGHT, and it applies only when dec_rd_we.
- dec_ready = rst & !flush & room & !hazard & !full.
- Accept (dec_valid & dec_ready): the issue register loads the payload and iss_valid=1 next cycle. Latency decode→iss_valid is 1 cycle.
- Issue register without accept: on fire, iss_valid clears; otherwise it holds and the payload stays stable while iss_valid=1 and iss_ready=0.
- Flush: iss_valid clears at the next edge and the held instruction never fires.
  - Flush and fire in the same cycle: fire wins, and the scoreboard updates for the issued instruction (EX owns killing it).
  - The scoreboard is not rolled back by flush.
- stall_cnt increments when dec_valid & !dec_ready & rst, and saturates at all-ones.
- Reset mid-operation: all state is cleared in one cycle; writebacks outstanding at reset are discarded.

Decomposition:
- Shared package (riscv_pkg): inst_decoded_t, REG_IDX_W=5, NREGS, X0 constant.
- Sub-module: reg_scoreboard, holding the busy vector, the inflight counter and the set/clear priority. It exports busy_vec and inflight.
- decode_issue_ctrl holds the issue register, hazard logic, handshake and perf counter.

Test Plan:
- Reset: hold rst=0 for 3 cycles with dec_valid=1 → dec_ready=0, iss_valid=0, busy_vec=0, stall_cnt=0.
- Back-to-back RAW on a held producer:
  - add x5 accepted, iss_ready=0; next decode uses rs1=x5 → dec_ready=0.
  - iss_ready=1 → busy[5]=1.
  - wb_valid with wb_rd=5 → consumer accepted that same cycle via bypass.
- x0 writer: rd=0, rd_we=1 issued → busy_vec stays 0 and inflight stays 0; dependent rs1=0 accepted immediately.
- Capacity: MAX_INFLIGHT=4 and 4 writes issued to x1..x4 with no writeback → a 5th writer is stalled while a store (rd_we=0) is accepted. One wb_valid → the 5th writer is accepted.
- Flush: iss_valid=1, iss_ready=0, flush=1 → iss_valid=0 next cycle, busy_vec unchanged, dec_ready=0 during the flush cycle. Repeat with iss_ready=1 → the instruction fires and busy[rd] is set.
- Set/clear collision: busy[7]=1; in one cycle wb_rd=7 and a new x7 writer fires → busy[7]=1 and inflight unchanged. stall_cnt saturates after forced all-ones preload.
